// File: rtl/hvac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hvac_pkg
// Purpose  : Shared types and defaults for the HVAC zone scheduler.
//            FSM state encoding, plant mode encoding, default thresholds,
//            zone count and the round-robin zone picker.
// Revision : 1.0  initial release
// ============================================================================
package hvac_pkg;

  localparam int NUM_ZONES = 4;
  localparam int TEMP_W    = 5;

  localparam logic [TEMP_W-1:0] T_HEAT_ON_DEFAULT = 5'd18;
  localparam logic [TEMP_W-1:0] T_COOL_ON_DEFAULT = 5'd22;
  localparam logic [TEMP_W-1:0] T_TARGET_DEFAULT  = 5'd20;

  localparam int MIN_DWELL_DEFAULT = 4;
  localparam int MAX_DWELL_DEFAULT = 16;
  localparam int DEADTIME_DEFAULT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_SERVE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_HEAT = 2'd1,
    MODE_COOL = 2'd2
  } mode_t;

  // First demanding zone after 'base', wrapping 3->0; 'base' itself is
  // considered last. Returns {found, zone}.
  function automatic logic [2:0] rr_pick(input logic [NUM_ZONES-1:0] dem,
                                         input logic [1:0]           base);
    logic       found;
    logic [1:0] idx;
    logic [1:0] sel;
    found = 1'b0;
    sel   = base;
    for (int k = 1; k <= NUM_ZONES; k++) begin
      idx = base + 2'(k);
      if (!found && dem[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hvac_zone_scheduler_zone_demand.sv
`default_nettype none
// ============================================================================
// Module   : zone_demand
// Purpose  : Per-zone hysteresis. Registers heat and cool demand flags from
//            one zone temperature.
// Ports    : clk, rst_n (sync, active-low)
//            temp      [4:0] zone temperature, unsigned
//            req_heat        heat demand (registered)
//            req_cool        cool demand (registered)
// Revision : 1.0  initial release
// ============================================================================
module zone_demand
  import hvac_pkg::*;
#(
  parameter logic [TEMP_W-1:0] T_HEAT_ON = T_HEAT_ON_DEFAULT,
  parameter logic [TEMP_W-1:0] T_COOL_ON = T_COOL_ON_DEFAULT,
  parameter logic [TEMP_W-1:0] T_TARGET  = T_TARGET_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TEMP_W-1:0] temp,
  output logic              req_heat,
  output logic              req_cool
);

  // With T_HEAT_ON < T_TARGET < T_COOL_ON the two flags are mutually
  // exclusive: setting one implies the clear condition of the other.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_heat <= 1'b0;
      req_cool <= 1'b0;
    end else begin
      if (temp <= T_HEAT_ON)     req_heat <= 1'b1;
      else if (temp >= T_TARGET) req_heat <= 1'b0;

      if (temp >= T_COOL_ON)     req_cool <= 1'b1;
      else if (temp <= T_TARGET) req_cool <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hvac_zone_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hvac_zone_scheduler
// Purpose  : Time-shares one heating/cooling plant between four zones with
//            round-robin grants, minimum/maximum dwell and heat/cool dead time.
// Ports    : clk, rst_n (sync, active-low)
//            temperature [19:0] four packed 5-bit zone temperatures
//            enable             low blocks new grants
//            heating, cooling   plant drives (registered)
//            zone_sel    [1:0]  damper select of granted zone (registered)
//            busy               high while serving (registered)
// Revision : 1.0  initial release
// ============================================================================
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter logic [TEMP_W-1:0] T_HEAT_ON = T_HEAT_ON_DEFAULT,
  parameter logic [TEMP_W-1:0] T_COOL_ON = T_COOL_ON_DEFAULT,
  parameter logic [TEMP_W-1:0] T_TARGET  = T_TARGET_DEFAULT,
  parameter int                MIN_DWELL = MIN_DWELL_DEFAULT,
  parameter int                MAX_DWELL = MAX_DWELL_DEFAULT,
  parameter int                DEADTIME  = DEADTIME_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_ZONES*TEMP_W-1:0] temperature,
  input  logic                        enable,
  output logic                        heating,
  output logic                        cooling,
  output logic [1:0]                  zone_sel,
  output logic                        busy
);

  localparam int DWELL_W = $clog2(MAX_DWELL);
  localparam int OFF_W   = $clog2(DEADTIME + 1);

  localparam logic [DWELL_W-1:0] MIN_LAST = DWELL_W'(MIN_DWELL - 1);
  localparam logic [DWELL_W-1:0] MAX_LAST = DWELL_W'(MAX_DWELL - 1);
  localparam logic [OFF_W-1:0]   OFF_SAT  = OFF_W'(DEADTIME);

  logic [NUM_ZONES-1:0] req_heat;
  logic [NUM_ZONES-1:0] req_cool;
  logic [NUM_ZONES-1:0] demand;

  for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
    zone_demand #(
      .T_HEAT_ON (T_HEAT_ON),
      .T_COOL_ON (T_COOL_ON),
      .T_TARGET  (T_TARGET)
    ) u_zone_demand (
      .clk      (clk),
      .rst_n    (rst_n),
      .temp     (temperature[TEMP_W*i +: TEMP_W]),
      .req_heat (req_heat[i]),
      .req_cool (req_cool[i])
    );
  end

  assign demand = req_heat | req_cool;

  state_t               state, state_n;
  mode_t                mode, mode_n, last_mode, last_mode_n;
  logic [1:0]           zone, zone_n, last_served, last_served_n, zone_sel_n;
  logic [DWELL_W-1:0]   dwell, dwell_n;
  logic [OFF_W-1:0]     off_cnt;
  logic                 drive_n, heat_n, cool_n;

  // Two pickers: one from last_served (IDLE), one from the zone currently
  // served, which becomes last_served on the releasing edge.
  logic [2:0] idle_pick, rel_pick;
  mode_t      idle_mode, rel_mode;
  logic       off_ok, others_waiting, grant_done;

  assign idle_pick      = rr_pick(demand, last_served);
  assign rel_pick       = rr_pick(demand, zone);
  assign idle_mode      = req_heat[idle_pick[1:0]] ? MODE_HEAT : MODE_COOL;
  assign rel_mode       = req_heat[rel_pick[1:0]]  ? MODE_HEAT : MODE_COOL;
  assign off_ok         = (off_cnt >= OFF_SAT);
  assign others_waiting = |(demand & ~(NUM_ZONES'(1) << zone));
  assign grant_done     = ((dwell >= MIN_LAST) && (!demand[zone] || !enable)) ||
                          ((dwell >= MAX_LAST) && others_waiting);

  always_comb begin
    state_n       = state;
    zone_n        = zone;
    mode_n        = mode;
    last_served_n = last_served;
    last_mode_n   = last_mode;
    dwell_n       = dwell;
    zone_sel_n    = zone_sel;
    drive_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && idle_pick[2]) begin
          zone_n  = idle_pick[1:0];
          mode_n  = idle_mode;
          dwell_n = '0;
          if ((idle_mode == last_mode) || off_ok) begin
            state_n    = ST_SERVE;
            drive_n    = 1'b1;
            zone_sel_n = idle_pick[1:0];
          end else begin
            state_n = ST_SWITCH;
          end
        end
      end
      ST_SWITCH: begin
        if (off_ok) begin
          state_n    = ST_SERVE;
          drive_n    = 1'b1;
          zone_sel_n = zone;
          dwell_n    = '0;
        end
      end
      ST_SERVE: begin
        drive_n = 1'b1;
        // Saturate so an unbounded grant cannot wrap below MIN_LAST.
        if (dwell != MAX_LAST) dwell_n = dwell + 1'b1;
        if (grant_done) begin
          last_served_n = zone;
          last_mode_n   = mode;
          if (!enable || !rel_pick[2]) begin
            state_n = ST_IDLE;
            drive_n = 1'b0;
          end else if (rel_mode == mode) begin
            // Same-mode handover keeps the plant running without a gap.
            zone_n     = rel_pick[1:0];
            zone_sel_n = rel_pick[1:0];
            dwell_n    = '0;
          end else begin
            state_n = ST_SWITCH;
            zone_n  = rel_pick[1:0];
            mode_n  = rel_mode;
            drive_n = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    heat_n = drive_n && (mode_n == MODE_HEAT);
    cool_n = drive_n && (mode_n == MODE_COOL);
  end

  // off_cnt counts the upcoming output cycle, so it reads as the number of
  // consecutive low cycles including the present one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      zone        <= 2'd0;
      mode        <= MODE_NONE;
      last_served <= 2'd3;
      last_mode   <= MODE_NONE;
      dwell       <= '0;
      off_cnt     <= OFF_SAT;
      heating     <= 1'b0;
      cooling     <= 1'b0;
      zone_sel    <= 2'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      zone        <= zone_n;
      mode        <= mode_n;
      last_served <= last_served_n;
      last_mode   <= last_mode_n;
      dwell       <= dwell_n;
      heating     <= heat_n;
      cooling     <= cool_n;
      zone_sel    <= zone_sel_n;
      busy        <= (state_n == ST_SERVE);
      if (heat_n || cool_n)      off_cnt <= '0;
      else if (off_cnt != OFF_SAT) off_cnt <= off_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hvac_zone_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hvac_zone_scheduler
// Purpose  : Self-checking bench for hvac_zone_scheduler: directed scenarios
//            plus randomized temperatures against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hvac_zone_scheduler;

  localparam int MIN_D = 4;
  localparam int MAX_D = 16;
  localparam int DT    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] temperature;
  logic        enable = 1'b1;
  logic        heating, cooling, busy;
  logic [1:0]  zone_sel;

  int passed = 0;
  int total  = 0;
  int temps[4];

  hvac_zone_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .temperature (temperature),
    .enable      (enable),
    .heating     (heating),
    .cooling     (cooling),
    .zone_sel    (zone_sel),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Modes: 0 none, 1 heat, 2 cool. grant/pend = -1 when absent.
  int m_hf[4], m_cf[4];
  int m_grant, m_gmode, m_pend, m_pmode, m_len;
  int m_last_zone, m_last_mode, m_low_run;
  int m_heat, m_cool, m_sel, m_busy;

  function automatic int m_wants(int z);
    return (m_hf[z] != 0 || m_cf[z] != 0) ? 1 : 0;
  endfunction

  function automatic int m_next(int base);
    for (int k = 1; k <= 4; k++)
      if (m_wants((base + k) % 4) != 0) return (base + k) % 4;
    return -1;
  endfunction

  function automatic int m_mode_of(int z);
    return (m_hf[z] != 0) ? 1 : 2;
  endfunction

  function automatic void model_reset();
    for (int z = 0; z < 4; z++) begin m_hf[z] = 0; m_cf[z] = 0; end
    m_grant = -1; m_pend = -1; m_gmode = 0; m_pmode = 0; m_len = 0;
    m_last_zone = 3; m_last_mode = 0; m_low_run = DT;
    m_heat = 0; m_cool = 0; m_sel = 0; m_busy = 0;
  endfunction

  function automatic void model_step();
    int c;
    int others;
    if (rst_n !== 1'b1) begin model_reset(); return; end
    if (m_grant >= 0) begin
      m_len++;
      others = 0;
      for (int z = 0; z < 4; z++) if (z != m_grant && m_wants(z) != 0) others = 1;
      if ((m_len >= MIN_D && (m_wants(m_grant) == 0 || !enable)) ||
          (m_len >= MAX_D && others != 0)) begin
        m_last_zone = m_grant;
        m_last_mode = m_gmode;
        c = m_next(m_last_zone);
        if (!enable || c < 0) m_grant = -1;
        else if (m_mode_of(c) == m_gmode) begin m_grant = c; m_len = 0; end
        else begin m_grant = -1; m_pend = c; m_pmode = m_mode_of(c); end
      end
    end else if (m_pend >= 0) begin
      if (m_low_run >= DT) begin
        m_grant = m_pend; m_gmode = m_pmode; m_pend = -1; m_len = 0;
      end
    end else if (enable) begin
      c = m_next(m_last_zone);
      if (c >= 0) begin
        if (m_mode_of(c) == m_last_mode || m_low_run >= DT) begin
          m_grant = c; m_gmode = m_mode_of(c); m_len = 0;
        end else begin
          m_pend = c; m_pmode = m_mode_of(c);
        end
      end
    end
    m_heat = (m_grant >= 0 && m_gmode == 1) ? 1 : 0;
    m_cool = (m_grant >= 0 && m_gmode == 2) ? 1 : 0;
    if (m_grant >= 0) m_sel = m_grant;
    m_busy = (m_grant >= 0) ? 1 : 0;
    m_low_run = (m_heat != 0 || m_cool != 0) ? 0 : m_low_run + 1;
    for (int z = 0; z < 4; z++) begin
      if (temps[z] <= 18)      m_hf[z] = 1;
      else if (temps[z] >= 20) m_hf[z] = 0;
      if (temps[z] >= 22)      m_cf[z] = 1;
      else if (temps[z] <= 20) m_cf[z] = 0;
    end
  endfunction

  function automatic logic [4:0] exp_vec();
    return {1'(m_heat), 1'(m_cool), 2'(m_sel), 1'(m_busy)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_temps();
    temperature = {5'(temps[3]), 5'(temps[2]), 5'(temps[1]), 5'(temps[0])};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    for (int z = 0; z < 4; z++) temps[z] = 20;
    set_temps();
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    total++;
    if ({heating, cooling, zone_sel, busy} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {heating, cooling, zone_sel, busy});
    else passed++;
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      total++;
      if ({heating, cooling, busy} !== 3'b000)
        $display("FAIL idle_no_grant: got h=%b c=%b b=%b want 0", heating, cooling, busy);
      else passed++;
      total++;
      if ({heating, cooling, zone_sel, busy} !== exp_vec())
        $display("FAIL idle_model: got %b want %b", {heating, cooling, zone_sel, busy}, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_single_heat();
    int hi;
    apply_reset();
    rst_n = 1'b1;
    temps[2] = 16; set_temps();
    tick();
    total++;
    if (heating !== 1'b0) $display("FAIL single_early: got heating=%b want 0", heating);
    else passed++;
    tick();
    total++;
    if ({heating, zone_sel} !== 3'b110)
      $display("FAIL single_grant: got heating=%b zone_sel=%0d want 1/2", heating, zone_sel);
    else passed++;
    hi = 1;
    repeat (6) begin
      tick();
      if (heating === 1'b1) hi++;
      total++;
      if ({heating, cooling, zone_sel, busy} !== exp_vec())
        $display("FAIL single_hold: got %b want %b", {heating, cooling, zone_sel, busy}, exp_vec());
      else passed++;
    end
    temps[2] = 20; set_temps();
    for (int n = 0; n < 10 && busy === 1'b1; n++) begin
      tick();
      if (heating === 1'b1) hi++;
      total++;
      if ({heating, cooling, zone_sel, busy} !== exp_vec())
        $display("FAIL single_release: got %b want %b", {heating, cooling, zone_sel, busy}, exp_vec());
      else passed++;
    end
    total++;
    if (heating !== 1'b0 || busy !== 1'b0 || hi < MIN_D)
      $display("FAIL single_end: got heating=%b busy=%b served=%0d want 0/0/>=4", heating, busy, hi);
    else passed++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    rst_n = 1'b1;
    temps[0] = 16; temps[3] = 16; set_temps();
    tick(); tick();
    total++;
    if ({heating, zone_sel} !== 3'b100)
      $display("FAIL rr_first: got heating=%b zone_sel=%0d want 1/0", heating, zone_sel);
    else passed++;
    for (int i = 1; i <= 48; i++) begin
      tick();
      total++;
      if (heating !== 1'b1 || cooling !== 1'b0)
        $display("FAIL rr_gap: cycle %0d got heating=%b cooling=%b want 1/0", i, heating, cooling);
      else passed++;
      if (i % 16 == 0) begin
        total++;
        if (zone_sel !== ((i / 16) % 2 == 1 ? 2'd3 : 2'd0))
          $display("FAIL rr_zone: cycle %0d got zone_sel=%0d want %0d", i, zone_sel,
                   ((i / 16) % 2 == 1) ? 3 : 0);
        else passed++;
      end
    end
  endtask

  task automatic test_mode_change();
    int lows;
    int n;
    apply_reset();
    rst_n = 1'b1;
    temps[0] = 16; set_temps();
    tick(); tick(); tick();
    temps[1] = 24; set_temps();
    n = 0;
    while (heating === 1'b1 && n < 30) begin tick(); n++; end
    total++;
    if (heating !== 1'b0) $display("FAIL mode_release_timeout: got heating=%b want 0", heating);
    else passed++;
    lows = 1;
    n = 0;
    while (cooling !== 1'b1 && n < 10) begin
      tick(); n++;
      total++;
      if ({heating, cooling, zone_sel, busy} !== exp_vec())
        $display("FAIL mode_model: got %b want %b", {heating, cooling, zone_sel, busy}, exp_vec());
      else passed++;
      if (cooling !== 1'b1) lows++;
    end
    total++;
    if (lows != DT || cooling !== 1'b1 || zone_sel !== 2'd1)
      $display("FAIL mode_deadtime: got lows=%0d cooling=%b zone_sel=%0d want 3/1/1", lows, cooling, zone_sel);
    else passed++;
  endtask

  task automatic test_min_dwell();
    int hi;
    int n;
    apply_reset();
    rst_n = 1'b1;
    temps[0] = 16; set_temps();
    n = 0;
    while (heating !== 1'b1 && n < 5) begin tick(); n++; end
    temps[0] = 20; set_temps();
    hi = (heating === 1'b1) ? 1 : 0;
    n = 0;
    while (heating === 1'b1 && n < 20) begin
      tick(); n++;
      if (heating === 1'b1) hi++;
    end
    total++;
    if (hi != MIN_D) $display("FAIL min_dwell: got %0d heating cycles want 4", hi);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    rst_n = 1'b1;
    temps[0] = 16; set_temps();
    tick(); tick(); tick(); tick();
    total++;
    if (busy !== 1'b1) $display("FAIL mid_serving: got busy=%b want 1", busy);
    else passed++;
    rst_n = 1'b0;
    temps[0] = 20; temps[1] = 16; set_temps();
    tick();
    total++;
    if ({heating, cooling, zone_sel, busy} !== 5'b0)
      $display("FAIL mid_reset: got %b want 00000", {heating, cooling, zone_sel, busy});
    else passed++;
    rst_n = 1'b1;
    n = 0;
    while (heating !== 1'b1 && n < 5) begin tick(); n++; end
    total++;
    if (heating !== 1'b1 || zone_sel !== 2'd1)
      $display("FAIL mid_first_grant: got heating=%b zone_sel=%0d want 1/1", heating, zone_sel);
    else passed++;
  endtask

  task automatic test_random();
    apply_reset();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 3) == 0) temps[$urandom_range(0, 3)] = $urandom_range(14, 26);
      set_temps();
      enable = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      tick();
      total++;
      if ({heating, cooling, zone_sel, busy} !== exp_vec())
        $display("FAIL random_model: cycle %0d got %b want %b", cyc,
                 {heating, cooling, zone_sel, busy}, exp_vec());
      else passed++;
      total++;
      if (heating === 1'b1 && cooling === 1'b1)
        $display("FAIL random_exclusive: cycle %0d got both drives high want at most one", cyc);
      else passed++;
    end
  endtask

  initial begin
    for (int z = 0; z < 4; z++) temps[z] = 20;
    set_temps();
    model_reset();
    test_reset();
    test_single_heat();
    test_round_robin();
    test_mode_change();
    test_min_dwell();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
